// File: rtl/uncached_store_queue.sv
// rtl/uncached_store_queue.sv - in-order uncached store queue feeding the SRAM write buffer
// Optional feature macro: UNCACHED_STORE_MERGE_EN (merge same-word stores into the tail entry).
// o_sram_req packing: {addr[31:0], len[7:0], size[2:0], wen[3:0]}.
module uncached_store_queue #(
  parameter int QUEUE_DEPTH     = 4,
  parameter int OUTSTANDING_MAX = 7
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_st_valid,
  output logic        o_st_ready,
  input  logic [31:0] i_st_addr,
  input  logic [3:0]  i_st_wen,
  input  logic [31:0] i_st_data,
  input  logic        i_load_valid,
  input  logic [31:0] i_load_addr,
  output logic        o_load_block,
  input  logic        i_sync,
  output logic        o_sync_done,
  input  logic        i_sram_full,
  input  logic        i_sram_end,
  output logic        o_sram_we,
  output logic [46:0] o_sram_req,
  output logic [31:0] o_sram_data,
  output logic        o_idle
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int OUT_W = $clog2(OUTSTANDING_MAX + 1);
  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(QUEUE_DEPTH);
  localparam logic [OUT_W-1:0] OUT_MAX_C = OUT_W'(OUTSTANDING_MAX);

  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

  state_t           state;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic [OUT_W-1:0] outstanding;
  logic [OUT_W-1:0] out_next;

  logic [29:0] q_addr [QUEUE_DEPTH];
  logic [3:0]  q_wen  [QUEUE_DEPTH];
  logic [31:0] q_data [QUEUE_DEPTH];

  logic             head_valid;
  logic             issue;
  logic             merge_hit;
  logic             accept;
  logic             push;
  logic [PTR_W-1:0] off [QUEUE_DEPTH];
  logic [QUEUE_DEPTH-1:0] entry_valid;
  logic             addr_hit;

  // Low address bits are implied by the strobes and never needed from the inputs.
  logic unused_low_bits;
  assign unused_low_bits = ^{i_st_addr[1:0], i_load_addr[1:0]};

  function automatic logic [2:0] size_of(input logic [3:0] wen);
    case (wen)
      4'b0011, 4'b1100:                   size_of = 3'd1;
      4'b0001, 4'b0010, 4'b0100, 4'b1000: size_of = 3'd0;
      default:                            size_of = 3'd2;
    endcase
  endfunction

  function automatic logic [1:0] low_off(input logic [3:0] wen);
    if (wen[0])      low_off = 2'd0;
    else if (wen[1]) low_off = 2'd1;
    else if (wen[2]) low_off = 2'd2;
    else             low_off = 2'd3;
  endfunction

  assign head_valid = (count != '0);
  assign issue      = head_valid && !i_sram_full && (outstanding < OUT_MAX_C);
  assign o_sram_we  = issue;

`ifdef UNCACHED_STORE_MERGE_EN
  logic [PTR_W-1:0] tail_ptr;
  assign tail_ptr  = wr_ptr - PTR_W'(1);
  // The tail is only safe to merge into if it is not leaving the queue this cycle.
  assign merge_hit = head_valid && (q_addr[tail_ptr] == i_st_addr[31:2]) &&
                     !(issue && (count == CNT_W'(1)));
`else
  assign merge_hit = 1'b0;
`endif

  assign o_st_ready = (state == RUN) && ((count < DEPTH_C) || merge_hit);
  assign accept     = i_st_valid && o_st_ready;
  assign push       = accept && !merge_hit;
  assign o_idle     = (count == '0) && (outstanding == '0);

  // Present the head entry as a single-beat write request; zero when empty.
  always_comb begin
    o_sram_req  = '0;
    o_sram_data = '0;
    if (head_valid) begin
      o_sram_req  = {q_addr[rd_ptr], low_off(q_wen[rd_ptr]), 8'd0,
                     size_of(q_wen[rd_ptr]), q_wen[rd_ptr]};
      o_sram_data = q_data[rd_ptr];
    end
  end

  // Word-address match against every live queue entry for the load hazard.
  always_comb begin
    addr_hit    = 1'b0;
    entry_valid = '0;
    for (int i = 0; i < QUEUE_DEPTH; i++) begin
      off[i]         = PTR_W'(i) - rd_ptr;
      entry_valid[i] = ({1'b0, off[i]} < count);
      if (entry_valid[i] && (q_addr[i] == i_load_addr[31:2])) addr_hit = 1'b1;
    end
  end

  assign o_load_block = i_load_valid && (addr_hit || (outstanding != '0));

  // Next-state values for occupancy and outstanding stores.
  always_comb begin
    count_next = count;
    if (push && !issue)      count_next = count + CNT_W'(1);
    else if (issue && !push) count_next = count - CNT_W'(1);
    out_next = outstanding;
    if (issue && !i_sram_end)                             out_next = outstanding + OUT_W'(1);
    else if (!issue && i_sram_end && outstanding != '0)   out_next = outstanding - OUT_W'(1);
  end

  // Queue pointers, occupancy and outstanding counter.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + PTR_W'(1);
      if (issue) rd_ptr <= rd_ptr + PTR_W'(1);
      count       <= count_next;
      outstanding <= out_next;
    end
  end

  // Entry storage: new entries at the tail, or byte-merge into the tail.
  always_ff @(posedge i_clk) begin
    if (push) begin
      q_addr[wr_ptr] <= i_st_addr[31:2];
      q_wen[wr_ptr]  <= i_st_wen;
      q_data[wr_ptr] <= i_st_data;
    end
`ifdef UNCACHED_STORE_MERGE_EN
    else if (accept) begin
      q_wen[tail_ptr] <= q_wen[tail_ptr] | i_st_wen;
      for (int b = 0; b < 4; b++) begin
        if (i_st_wen[b]) q_data[tail_ptr][8*b +: 8] <= i_st_data[8*b +: 8];
      end
    end
`endif
  end

  // Sync FSM: drain everything, pulse done once, resume accepting.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state       <= RUN;
      o_sync_done <= 1'b0;
    end else begin
      o_sync_done <= 1'b0;
      case (state)
        RUN: if (i_sync) state <= DRAIN;
        DRAIN: begin
          if ((count_next == '0) && (out_next == '0)) begin
            state       <= DONE;
            o_sync_done <= 1'b1;
          end
        end
        DONE:    state <= i_sync ? DRAIN : RUN;
        default: state <= RUN;
      endcase
    end
  end

endmodule
